mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Multi-cycle HI/LO multiply/divide unit in the E stage. Executes mult/multu/div/divu/mthi/mtlo from decoded MDctrl.
//  Models fixed operation latency with a busy counter and supplies HI/LO for mfhi/mflo.
//  Exports start/busy so the hazard unit can stall D-stage MD instructions.
//  Honours exception flush so an instruction cancelled in E never starts.
// PARAMETERS
//  MULT_CYCLES  5   cycles busy asserts after a mult/multu start (>=1)
//  DIV_CYCLES   10  cycles busy asserts after a div/divu start (>=1)
// PORTS
//  clk       in   1   system clock, all state on rising edge
//  reset     in   1   synchronous, active-high
//  MDctrl    in   3   000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 none
//  HILOsel   in   1   read select: 1 HI, 0 LO
//  A         in   32  rs operand (forwarded)
//  B         in   32  rt operand (forwarded)
//  flush     in   1   exception/interrupt flush of E-stage instruction this cycle
//  start     out  1   comb: MDctrl is mult/multu/div/divu, not busy, not flush
//  busy      out  1   reg: operation in flight
//  HILO_out  out  32  comb: HILOsel ? HI : LO (architectural value)
// BEHAVIOUR
//  Reset: HI=0, LO=0, busy=0, count=0, pending result cleared. Applies mid-operation; in-flight result discarded.
//  Accept rule: a command is accepted only when busy==0 and flush==0. Otherwise it is ignored with no state change.
//    The hazard unit is responsible for stalling, so non-zero MDctrl while busy is a hazard-unit bug.
//  mult/multu/div/divu accept cycle:
//    - Compute the 64-bit result from A,B and hold it in pending {hi,lo}.
//    - Load count with MULT_CYCLES or DIV_CYCLES; busy=1 from the next cycle.
//  Busy phase: count decrements each cycle. On the edge where count goes 1->0:
//    - {HI,LO} <= pending and busy <= 0.
//    - Op accepted at edge t has busy high for exactly N cycles (t+1 .. t+N).
//    - HI/LO are visible at HILO_out from cycle t+N+1.
//  Arithmetic:
//    - mult: signed 32x32->64. multu: unsigned. HI=upper, LO=lower.
//    - div: $signed quotient->LO, remainder->HI; quotient truncates toward zero, remainder takes dividend sign.
//    - divu: unsigned.
//    - B==0 (div/divu): full latency, HI/LO unchanged at completion.
//    - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
//  mthi/mtlo: if accepted, HI<=A or LO<=A at the next edge. Zero latency, busy stays 0.
//  HILO_out: HI/LO are never updated early during busy; the value stays the old one until completion.
//  flush:
//    - Only blocks a new start; an op already in flight runs to completion (precise-exception semantics).
//    - flush with mthi/mtlo: no write.
//  start is purely combinational, for the hazard unit: stall_MD = (start|busy) & D_uses_MD.
// STRUCTURE
//  Shared package/header md_defs: MDctrl encodings (MD_NONE..MD_MTLO), HILOsel values.
//    The controller uses the same constants.
//  Sub-module md_compute: combinational A,B,op -> {hi,lo} with signed/unsigned mul/div.
//    Includes the divide-by-zero bypass flag.
//  Top: accept logic, 4-bit countdown, pending register, HI/LO registers.
// TESTING
//  1. Reset, then mult A=0xFFFFFFFE B=3:
//     busy 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu same operands -> HI=0x2, LO=0xFFFFFFFA.
//  2. div A=-7 (0xFFFFFFF9) B=2:
//     busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7/2 -> LO=3, HI=1.
//  3. mthi 0x1234, next cycle mtlo 0x5678:
//     busy never high; HILOsel=1 -> 0x1234, HILOsel=0 -> 0x5678.
//  4. mult with flush=1 in accept cycle:
//     start=0, busy stays 0, HI/LO unchanged.
//     Flush mid-busy -> op completes with correct result.
//  5. Reset asserted at busy cycle 3 of a div:
//     next cycle busy=0, HI=LO=0, no late write-back.
//  6. divu B=0 after HI=0xA, LO=0xB preset:
//     busy 10 cycles; HI=0xA, LO=0xB retained.
//     mult issued while busy -> ignored, result of first op intact.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit. The controller decodes
// to the same MDctrl encodings.
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'b000,
    MD_MULT  = 3'b001,
    MD_MULTU = 3'b010,
    MD_DIV   = 3'b011,
    MD_DIVU  = 3'b100,
    MD_MTHI  = 3'b101,
    MD_MTLO  = 3'b110,
    MD_NONE7 = 3'b111
  } md_op_e;

  localparam logic HILO_SEL_HI = 1'b1;
  localparam logic HILO_SEL_LO = 1'b0;

  // Wide enough for latencies up to 15 cycles.
  localparam int COUNT_W = 4;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } md_state_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;
  } md_result_t;

  function automatic logic is_mult(md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div(md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_muldiv(md_op_e op);
    return is_mult(op) || is_div(op);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// E-stage command/result bundle between the pipeline controller (master) and
// the multiply/divide unit (slave).
interface mult_div_unit_if;
  import mult_div_unit_pkg::*;

  md_op_e      MDctrl;
  logic        HILOsel;
  logic [31:0] A;
  logic [31:0] B;
  logic        flush;
  logic        start;
  logic        busy;
  logic [31:0] HILO_out;

  modport master (
    output MDctrl, HILOsel, A, B, flush,
    input  start, busy, HILO_out
  );

  modport slave (
    input  MDctrl, HILOsel, A, B, flush,
    output start, busy, HILO_out
  );

endinterface

// File: rtl/mult_div_unit_compute.sv
// Combinational 32x32 multiply/divide datapath producing {hi,lo} plus a
// divide-by-zero flag that tells the top to skip the write-back.
module mult_div_unit_compute
  import mult_div_unit_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output md_result_t  result
);

  logic [63:0] a_sx;
  logic [63:0] b_sx;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        b_zero;
  logic        div_ovf;
  logic [31:0] divisor_u;
  logic [31:0] divisor_s;
  logic [31:0] quot_s;
  logic [31:0] rem_s;
  logic [31:0] quot_u;
  logic [31:0] rem_u;

  assign a_sx   = {{32{a[31]}}, a};
  assign b_sx   = {{32{b[31]}}, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'b0, a} * {32'b0, b};

  assign b_zero  = (b == 32'h0);
  assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  // Zero and the single overflowing signed pair never reach the dividers.
  assign divisor_u = b_zero ? 32'h1 : b;
  assign divisor_s = (b_zero || div_ovf) ? 32'h1 : b;

  assign quot_s = $signed(a) / $signed(divisor_s);
  assign rem_s  = $signed(a) % $signed(divisor_s);
  assign quot_u = a / divisor_u;
  assign rem_u  = a % divisor_u;

  // NOTE: every output of a combinational block gets a default first so no
  // op value can leave it unassigned and infer a latch.
  always_comb begin
    result = '0;
    unique case (op)
      MD_MULT:  {result.hi, result.lo} = prod_s;
      MD_MULTU: {result.hi, result.lo} = prod_u;
      MD_DIV: begin
        result.div_by_zero = b_zero;
        if (div_ovf) begin
          result.lo = 32'h8000_0000;
          result.hi = 32'h0;
        end else begin
          result.lo = quot_s;
          result.hi = rem_s;
        end
      end
      MD_DIVU: begin
        result.div_by_zero = b_zero;
        result.lo          = quot_u;
        result.hi          = rem_u;
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: fixed-latency busy countdown, pending result
// register and architectural HI/LO with mthi/mtlo and mfhi/mflo read path.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic            clk,
  input  logic            reset,
  mult_div_unit_if.slave  md
);

  localparam logic [COUNT_W-1:0] MULT_LOAD = COUNT_W'(MULT_CYCLES);
  localparam logic [COUNT_W-1:0] DIV_LOAD  = COUNT_W'(DIV_CYCLES);
  localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

  md_state_e          state;
  md_state_e          state_next;
  logic [COUNT_W-1:0] count;
  logic [COUNT_W-1:0] count_next;
  logic               write_back;

  md_result_t         pending;
  md_result_t         compute_result;
  logic [31:0]        hi;
  logic [31:0]        lo;

  md_op_e             op;
  logic               busy;
  logic               accept;
  logic               start;

  assign op     = md.MDctrl;
  assign busy   = (state == ST_BUSY);
  // Flush cancels the E-stage instruction only; it never aborts an op in flight.
  assign accept = !busy && !md.flush;
  assign start  = accept && is_muldiv(op);

  mult_div_unit_compute u_compute (
    .op     (op),
    .a      (md.A),
    .b      (md.B),
    .result (compute_result)
  );

  always_comb begin
    state_next = state;
    count_next = count;
    write_back = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_BUSY;
          count_next = is_mult(op) ? MULT_LOAD : DIV_LOAD;
        end
      end
      ST_BUSY: begin
        if (count == COUNT_ONE) begin
          write_back = 1'b1;
          state_next = ST_IDLE;
          count_next = '0;
        end else begin
          count_next = count - COUNT_ONE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        count_next = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      count <= '0;
      // The pending result is cleared too, so a reset mid-operation can never
      // leak a stale product into HI/LO later.
      pending <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state <= state_next;
      count <= count_next;

      if (start) begin
        pending <= compute_result;
      end

      if (write_back && !pending.div_by_zero) begin
        hi <= pending.hi;
        lo <= pending.lo;
      end

      if (accept && (op == MD_MTHI)) begin
        hi <= md.A;
      end
      if (accept && (op == MD_MTLO)) begin
        lo <= md.A;
      end
    end
  end

  assign md.start    = start;
  assign md.busy     = busy;
  assign md.HILO_out = (md.HILOsel == HILO_SEL_HI) ? hi : lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, hand-written
// multi-cycle corner sequences and randomized ops against a plain-arithmetic model.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mult_div_unit_if md ();

  mult_div_unit #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  typedef struct {
    string       name;
    md_op_e      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int exp_latency(md_op_e op);
    case (op)
      MD_MULT, MD_MULTU: return MULT_N;
      MD_DIV, MD_DIVU:   return DIV_N;
      default:           return 0;
    endcase
  endfunction

  // Architectural effect of one accepted op, computed in 64-bit integers.
  function automatic void model(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                                inout logic [31:0] hi, inout logic [31:0] lo);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, pu;
    case (op)
      MD_MULT: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa * sb;
        {hi, lo} = q;
      end
      MD_MULTU: begin
        ua = 64'(a);
        ub = 64'(b);
        pu = ua * ub;
        {hi, lo} = pu;
      end
      MD_DIV: begin
        if (b != 0) begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
          q  = sa / sb;
          r  = sa % sb;
          lo = q[31:0];
          hi = r[31:0];
        end
      end
      MD_DIVU: begin
        if (b != 0) begin
          lo = a / b;
          hi = a % b;
        end
      end
      MD_MTHI: hi = a;
      MD_MTLO: lo = a;
      default: ;
    endcase
  endfunction

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    md.HILOsel = 1'b1;
    #1 hi = md.HILO_out;
    md.HILOsel = 1'b0;
    #1 lo = md.HILO_out;
    md.HILOsel = 1'b1;
  endtask

  // Issue one op, measure busy length, check HI stays old while busy, then
  // check the final HI/LO. Optionally drive something on busy cycle inject_at.
  task automatic run_op(input string tag, input md_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic fl, input logic exp_start,
                        input int exp_n, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input int inject_at = 0, input md_op_e inject_op = MD_NONE,
                        input logic inject_flush = 1'b0);
    logic        st, inj_st;
    int          n, early;
    logic [31:0] h, l;
    @(negedge clk);
    md.HILOsel = 1'b1;
    md.MDctrl  = op;
    md.A       = a;
    md.B       = b;
    md.flush   = fl;
    #1 st = md.start;
    check({tag, " start"}, 32'(st), 32'(exp_start));
    @(negedge clk);
    md.MDctrl = MD_NONE;
    md.flush  = 1'b0;
    md.A      = $urandom;
    md.B      = $urandom;
    n      = 0;
    early  = 0;
    inj_st = 1'b0;
    while (md.busy && n < 64) begin
      n++;
      if (md.HILO_out !== m_hi) early++;
      if (n == inject_at) begin
        md.MDctrl = inject_op;
        md.flush  = inject_flush;
        md.A      = $urandom;
        md.B      = $urandom;
      end
      #1 if (n == inject_at) inj_st = md.start;
      @(negedge clk);
      md.MDctrl = MD_NONE;
      md.flush  = 1'b0;
    end
    check({tag, " busy_cycles"}, 32'(n), 32'(exp_n));
    check({tag, " hi_held_while_busy"}, 32'(early), 32'd0);
    if (inject_at > 0) check({tag, " start_while_busy"}, 32'(inj_st), 32'd0);
    read_hilo(h, l);
    check({tag, " hi"}, h, exp_hi);
    check({tag, " lo"}, l, exp_lo);
    m_hi = exp_hi;
    m_lo = exp_lo;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] h, l, rh, rl;
    logic        fl;
    md_op_e      op;
    logic [31:0] a, b;
    int          busy_seen;

    vecs[0]  = '{"mult_neg2x3",   MD_MULT,  32'hFFFF_FFFE, 32'h3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, MULT_N};
    vecs[1]  = '{"multu_neg2x3",  MD_MULTU, 32'hFFFF_FFFE, 32'h3,         32'h0000_0002, 32'hFFFF_FFFA, MULT_N};
    vecs[2]  = '{"div_m7_2",      MD_DIV,   32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_N};
    vecs[3]  = '{"divu_7_2",      MD_DIVU,  32'h7,         32'h2,         32'h0000_0001, 32'h0000_0003, DIV_N};
    vecs[4]  = '{"div_ovf",       MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_N};
    vecs[5]  = '{"div_7_m2",      MD_DIV,   32'h7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DIV_N};
    vecs[6]  = '{"mult_min_sq",   MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MULT_N};
    vecs[7]  = '{"mthi_1234",     MD_MTHI,  32'h1234,      32'h0,         32'h0000_1234, 32'h0000_0000, 0};
    vecs[8]  = '{"mtlo_5678",     MD_MTLO,  32'h5678,      32'h0,         32'h0000_1234, 32'h0000_5678, 0};
    vecs[9]  = '{"multu_max_sq",  MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MULT_N};
    vecs[10] = '{"mthi_a",        MD_MTHI,  32'hA,         32'h0,         32'h0000_000A, 32'h0000_0001, 0};
    vecs[11] = '{"mtlo_b",        MD_MTLO,  32'hB,         32'h0,         32'h0000_000A, 32'h0000_000B, 0};
    vecs[12] = '{"divu_by_zero",  MD_DIVU,  32'h5,         32'h0,         32'h0000_000A, 32'h0000_000B, DIV_N};

    reset      = 1'b1;
    md.MDctrl  = MD_NONE;
    md.HILOsel = 1'b1;
    md.A       = 32'h0;
    md.B       = 32'h0;
    md.flush   = 1'b0;
    m_hi       = 32'h0;
    m_lo       = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset busy", 32'(md.busy), 32'd0);
    check("reset start", 32'(md.start), 32'd0);
    read_hilo(h, l);
    check("reset hi", h, 32'h0);
    check("reset lo", l, 32'h0);

    foreach (vecs[i]) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0,
             exp_latency(vecs[i].op) != 0, vecs[i].lat, vecs[i].hi, vecs[i].lo);
    end

    // Back-to-back mthi then mtlo: zero latency, busy never rises.
    busy_seen = 0;
    @(negedge clk);
    md.MDctrl = MD_MTHI;
    md.A      = 32'h1234;
    @(negedge clk);
    if (md.busy) busy_seen++;
    md.MDctrl = MD_MTLO;
    md.A      = 32'h5678;
    @(negedge clk);
    if (md.busy) busy_seen++;
    md.MDctrl = MD_NONE;
    @(negedge clk);
    if (md.busy) busy_seen++;
    check("b2b_mt busy", 32'(busy_seen), 32'd0);
    read_hilo(h, l);
    check("b2b_mt hi", h, 32'h1234);
    check("b2b_mt lo", l, 32'h5678);
    m_hi = 32'h1234;
    m_lo = 32'h5678;

    run_op("flush_accept", MD_MULT, 32'h7, 32'h9, 1'b1, 1'b0, 0, m_hi, m_lo);
    run_op("flush_mthi", MD_MTHI, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b0, 0, m_hi, m_lo);
    run_op("flush_mid", MD_MULT, 32'hFFFF_FFFE, 32'h3, 1'b0, 1'b1, MULT_N,
           32'hFFFF_FFFF, 32'hFFFF_FFFA, 2, MD_NONE, 1'b1);

    run_op("preset_hi", MD_MTHI, 32'hA, 32'h0, 1'b0, 1'b0, 0, 32'hA, m_lo);
    run_op("preset_lo", MD_MTLO, 32'hB, 32'h0, 1'b0, 1'b0, 0, 32'hA, 32'hB);
    run_op("busy_ignore", MD_DIVU, 32'h5, 32'h0, 1'b0, 1'b1, DIV_N,
           32'hA, 32'hB, 4, MD_MULT, 1'b0);
    run_op("busy_ignore_mthi", MD_MULT, 32'h3, 32'h4, 1'b0, 1'b1, MULT_N,
           32'h0, 32'hC, 2, MD_MTHI, 1'b0);

    // Reset during busy cycle 3 of a div discards the in-flight result.
    @(negedge clk);
    md.MDctrl = MD_DIV;
    md.A      = 32'd100;
    md.B      = 32'd7;
    @(negedge clk);
    md.MDctrl = MD_NONE;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid busy_before", 32'(md.busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid busy_after", 32'(md.busy), 32'd0);
    read_hilo(h, l);
    check("rst_mid hi", h, 32'h0);
    check("rst_mid lo", l, 32'h0);
    busy_seen = 0;
    repeat (DIV_N + 4) begin
      @(negedge clk);
      if (md.busy) busy_seen++;
    end
    check("rst_mid no_late_busy", 32'(busy_seen), 32'd0);
    read_hilo(h, l);
    check("rst_mid no_late_hi", h, 32'h0);
    check("rst_mid no_late_lo", l, 32'h0);
    m_hi = 32'h0;
    m_lo = 32'h0;

    for (int k = 0; k < 60; k++) begin
      op = md_op_e'($urandom_range(1, 6));
      a  = pick_operand();
      b  = pick_operand();
      fl = ($urandom_range(0, 7) == 0);
      rh = m_hi;
      rl = m_lo;
      if (!fl) model(op, a, b, rh, rl);
      run_op($sformatf("rand%0d_op%0d", k, op), op, a, b, fl,
             !fl && (exp_latency(op) != 0), fl ? 0 : exp_latency(op), rh, rl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
